// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM states, requester identity,
// byte-lane strobe generation and read-byte selection.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyCpu,
        StBusyFdc
    } arb_state_t;

    typedef enum logic {
        ReqCpu,
        ReqFdc
    } requester_t;

    // Reads fetch the whole word; writes enable only the lane holding the addressed byte.
    function automatic logic [1:0] lane_ds(input logic we, input logic a0);
        if (!we) begin
            return 2'b11;
        end
        return a0 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [15:0] q16, input logic a0);
        return a0 ? q16[15:8] : q16[7:0];
    endfunction

endpackage

// File: rtl/cpu_req_detect.sv
// CPU-side trigger detection: strobe rising edges and address changes under a held read,
// with capture of the address/data/direction of the most recent trigger.
module cpu_req_detect (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cpu_cs_i,
    input  logic        cpu_oe_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_a_i,
    input  logic [7:0]  cpu_d_i,
    output logic        trig_o,
    output logic [15:0] cap_a_o,
    output logic [7:0]  cap_d_o,
    output logic        cap_we_o
);

    logic        rd, wr;
    logic        rd_q, wr_q;
    logic [15:0] a_q;
    logic [15:0] cap_a_q;
    logic [7:0]  cap_d_q;
    logic        cap_we_q;

    assign rd = cpu_cs_i & cpu_oe_i;
    assign wr = cpu_cs_i & cpu_we_i;

    assign trig_o = (rd & ~rd_q) | (wr & ~wr_q) | (rd & rd_q & (cpu_a_i != a_q));

    always_ff @(posedge clk_i) begin
        // History tracks the bus in reset too, so strobes held through reset never fire.
        rd_q <= rd;
        wr_q <= wr;
        a_q  <= cpu_a_i;
        if (reset_i) begin
            cap_a_q  <= '0;
            cap_d_q  <= '0;
            cap_we_q <= 1'b0;
        end else if (trig_o) begin
            cap_a_q  <= cpu_a_i;
            cap_d_q  <= cpu_d_i;
            cap_we_q <= wr;
        end
    end

    assign cap_a_o  = cap_a_q;
    assign cap_d_o  = cap_d_q;
    assign cap_we_o = cap_we_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between the CPU bus and the FDC sector DMA.
// Define SDRAM_ARB_FAIRNESS_EN to bound consecutive CPU grants while the FDC waits.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] FDC_BASE    = 24'h010000,
    parameter int unsigned       MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_a,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_busy,
    input  logic              fdc_req,
    input  logic              fdc_we,
    input  logic [16:0]       fdc_a,
    input  logic [7:0]        fdc_d,
    output logic [7:0]        fdc_q,
    output logic              fdc_ack,
    output logic              port_req,
    input  logic              port_ack,
    output logic [ADDR_W-1:0] port_a,
    output logic [1:0]        port_ds,
    output logic              port_we,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q
);

    arb_state_t        state_q, state_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              fdc_pend_q, fdc_pend_d;
    logic [16:0]       fdc_a_q, fdc_a_d;
    logic [7:0]        fdc_d_q, fdc_d_d;
    logic              fdc_we_q, fdc_we_d;
    logic              cur_a0_q, cur_a0_d;
    logic              port_req_q, port_req_d;
    logic [ADDR_W-1:0] port_a_q, port_a_d;
    logic [1:0]        port_ds_q, port_ds_d;
    logic              port_we_q, port_we_d;
    logic [15:0]       port_d_q, port_d_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        fdc_rdata_q, fdc_rdata_d;
    logic              fdc_ack_q, fdc_ack_d;

    logic              cpu_trig;
    logic [15:0]       cpu_cap_a;
    logic [7:0]        cpu_cap_d;
    logic              cpu_cap_we;
    logic              fdc_accept;
    logic              port_done;
    logic              grant_valid;
    logic              fdc_first;
    requester_t        grant_who;

    cpu_req_detect u_cpu_req_detect (
        .clk_i    (clk),
        .reset_i  (reset),
        .cpu_cs_i (cpu_cs),
        .cpu_oe_i (cpu_oe),
        .cpu_we_i (cpu_we),
        .cpu_a_i  (cpu_a),
        .cpu_d_i  (cpu_d),
        .trig_o   (cpu_trig),
        .cap_a_o  (cpu_cap_a),
        .cap_d_o  (cpu_cap_d),
        .cap_we_o (cpu_cap_we)
    );

    // The FDC must wait for fdc_ack; extra requests while one is outstanding are dropped.
    assign fdc_accept  = fdc_req & ~fdc_pend_q & (state_q != StBusyFdc);
    assign port_done   = (port_ack == port_req_q);
    assign grant_valid = cpu_pend_q | fdc_pend_q;
    assign grant_who   = (cpu_pend_q & ~fdc_first) ? ReqCpu : ReqFdc;

`ifdef SDRAM_ARB_FAIRNESS_EN
    localparam int unsigned RunW = $clog2(MAX_CPU_RUN + 1);

    logic [RunW-1:0] run_q, run_d;

    always_comb begin
        run_d = run_q;
        if (state_q == StIdle && grant_valid) begin
            if (grant_who == ReqFdc) begin
                run_d = '0;
            end else if (fdc_pend_q) begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign fdc_first = fdc_pend_q & (run_q >= RunW'(MAX_CPU_RUN));
`else
    logic unused_max_cpu_run;
    assign unused_max_cpu_run = ^MAX_CPU_RUN;
    assign fdc_first          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cpu_pend_d  = cpu_pend_q;
        fdc_pend_d  = fdc_pend_q;
        fdc_a_d     = fdc_a_q;
        fdc_d_d     = fdc_d_q;
        fdc_we_d    = fdc_we_q;
        cur_a0_d    = cur_a0_q;
        port_req_d  = port_req_q;
        port_a_d    = port_a_q;
        port_ds_d   = port_ds_q;
        port_we_d   = port_we_q;
        port_d_d    = port_d_q;
        cpu_rdata_d = cpu_rdata_q;
        fdc_rdata_d = fdc_rdata_q;
        fdc_ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    port_req_d = ~port_req_q;
                    if (grant_who == ReqCpu) begin
                        port_a_d   = ADDR_W'(cpu_cap_a);
                        port_we_d  = cpu_cap_we;
                        port_ds_d  = lane_ds(cpu_cap_we, cpu_cap_a[0]);
                        port_d_d   = {cpu_cap_d, cpu_cap_d};
                        cur_a0_d   = cpu_cap_a[0];
                        cpu_pend_d = 1'b0;
                        state_d    = StBusyCpu;
                    end else begin
                        port_a_d   = FDC_BASE + ADDR_W'(fdc_a_q);
                        port_we_d  = fdc_we_q;
                        port_ds_d  = lane_ds(fdc_we_q, fdc_a_q[0]);
                        port_d_d   = {fdc_d_q, fdc_d_q};
                        cur_a0_d   = fdc_a_q[0];
                        fdc_pend_d = 1'b0;
                        state_d    = StBusyFdc;
                    end
                end
            end
            StBusyCpu: begin
                if (port_done) begin
                    if (!port_we_q) begin
                        cpu_rdata_d = byte_sel(port_q, cur_a0_q);
                    end
                    state_d = StIdle;
                end
            end
            StBusyFdc: begin
                if (port_done) begin
                    if (!port_we_q) begin
                        fdc_rdata_d = byte_sel(port_q, cur_a0_q);
                    end
                    fdc_ack_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh trigger re-pends even in the cycle its predecessor is granted.
        if (cpu_trig) begin
            cpu_pend_d = 1'b1;
        end
        if (fdc_accept) begin
            fdc_pend_d = 1'b1;
            fdc_a_d    = fdc_a;
            fdc_d_d    = fdc_d;
            fdc_we_d   = fdc_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cpu_pend_q  <= 1'b0;
            fdc_pend_q  <= 1'b0;
            fdc_a_q     <= '0;
            fdc_d_q     <= '0;
            fdc_we_q    <= 1'b0;
            cur_a0_q    <= 1'b0;
            port_req_q  <= 1'b0;
            port_a_q    <= '0;
            port_ds_q   <= 2'b11;
            port_we_q   <= 1'b0;
            port_d_q    <= '0;
            cpu_rdata_q <= '0;
            fdc_rdata_q <= '0;
            fdc_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_pend_q  <= cpu_pend_d;
            fdc_pend_q  <= fdc_pend_d;
            fdc_a_q     <= fdc_a_d;
            fdc_d_q     <= fdc_d_d;
            fdc_we_q    <= fdc_we_d;
            cur_a0_q    <= cur_a0_d;
            port_req_q  <= port_req_d;
            port_a_q    <= port_a_d;
            port_ds_q   <= port_ds_d;
            port_we_q   <= port_we_d;
            port_d_q    <= port_d_d;
            cpu_rdata_q <= cpu_rdata_d;
            fdc_rdata_q <= fdc_rdata_d;
            fdc_ack_q   <= fdc_ack_d;
        end
    end

    assign port_req = port_req_q;
    assign port_a   = port_a_q;
    assign port_ds  = port_ds_q;
    assign port_we  = port_we_q;
    assign port_d   = port_d_q;
    assign cpu_q    = cpu_rdata_q;
    assign fdc_q    = fdc_rdata_q;
    assign fdc_ack  = fdc_ack_q;
    assign cpu_busy = cpu_pend_q | (state_q == StBusyCpu);

endmodule
